mem_responder: RTL

- Main-memory model/controller answering the cache FSM's memory-side strobe protocol (MStrobe, MRW).
- Single-word writes for write-through and write-miss.
- Multi-beat line fills for read misses, after a programmable access latency.
- Completion is signalled with MRdy. A level-strobe guard state keeps a held MStrobe from being re-accepted.

---
 rtl/mem_pkg.sv | 26 ++
 rtl/mem_array.sv | 38 +++
 rtl/mem_responder.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the main-memory responder.
package mem_pkg;

    // Controller states; HOLD keeps a still-asserted level strobe from re-triggering.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        BURST = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4
    } state_e;

    localparam logic MRW_READ  = 1'b0;
    localparam logic MRW_WRITE = 1'b1;

    // Bits needed to index 'value' entries, never less than one.
    function automatic int unsigned log2_min1(input int unsigned value);
        int unsigned width;
        width = 32'd1;
        while ((32'd1 << width) < value) begin
            width = width + 32'd1;
        end
        return width;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: one write enable, one registered read port.
// Storage is never cleared; only the read-data register returns to zero on reset.
module mem_array #(
    parameter int DEPTH  = 32'd1024,
    parameter int DATA_W = 32'd32,
    parameter int IDX_W  = 32'd10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rdata_r;

    // Storage write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Registered read port; holds its last value when no read is issued
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_r <= {DATA_W{1'b0}};
        end else if (re) begin
            rdata_r <= mem_r[addr];
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder for the cache controller's MStrobe/MRW protocol:
// single-word writes and LINE_WORDS-beat line fills after LATENCY cycles.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W     = 32'd16,
    parameter int DATA_W     = 32'd32,
    parameter int DEPTH      = 32'd1024,
    parameter int LINE_WORDS = 32'd4,
    parameter int LATENCY    = 32'd4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MDataW,
    output logic [DATA_W-1:0] MDataR,
    output logic              MValid,
    output logic              MRdy,
    output logic              MBusy
);

    localparam int IDX_W  = log2_min1(DEPTH);
    localparam int CNT_W  = log2_min1(LATENCY);
    localparam int BEAT_W = log2_min1(LINE_WORDS);

    localparam logic [CNT_W-1:0]  LAT_LOAD    = CNT_W'(LATENCY - 32'd1);
    localparam logic [CNT_W-1:0]  CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(32'd1);
    localparam logic [BEAT_W-1:0] BEAT_ZERO   = {BEAT_W{1'b0}};
    localparam logic [BEAT_W-1:0] BEAT_ONE    = BEAT_W'(32'd1);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(LINE_WORDS - 32'd1);
    localparam logic [IDX_W-1:0]  LINE_MASK   = IDX_W'(LINE_WORDS - 32'd1);
    localparam logic              SINGLE_BEAT = (LINE_WORDS == 32'd1);

    state_e            state_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [BEAT_W-1:0] beat_r;
    logic              mrw_r;
    logic [IDX_W-1:0]  addr_r;
    logic [DATA_W-1:0] data_r;
    logic              mvalid_r;
    logic              mrdy_r;

    logic              we_s;
    logic              re_s;
    logic [IDX_W-1:0]  ram_addr_s;
    logic [IDX_W-1:0]  base_s;
    logic              unused_addr_s;

    // Upper address bits fold away: storage is indexed modulo DEPTH.
    assign unused_addr_s = ^MAddr;

    // RAM control: commit on the last WAIT cycle; beat reads go out one cycle
    // ahead so the registered RAM output lines up with MValid.
    always_comb begin
        base_s     = addr_r & ~LINE_MASK;
        we_s       = 1'b0;
        re_s       = 1'b0;
        ram_addr_s = base_s;
        if (reset) begin
            we_s = 1'b0;
            re_s = 1'b0;
        end else begin
            case (state_r)
                WAIT: begin
                    if (cnt_r == CNT_ZERO) begin
                        if (mrw_r == MRW_WRITE) begin
                            we_s       = 1'b1;
                            ram_addr_s = addr_r;
                        end else begin
                            re_s       = 1'b1;
                            ram_addr_s = base_s;
                        end
                    end else begin
                        we_s = 1'b0;
                        re_s = 1'b0;
                    end
                end
                BURST: begin
                    if (beat_r != LAST_BEAT) begin
                        re_s       = 1'b1;
                        ram_addr_s = base_s + IDX_W'(beat_r + BEAT_ONE);
                    end else begin
                        re_s = 1'b0;
                    end
                end
                default: begin
                    we_s = 1'b0;
                    re_s = 1'b0;
                end
            endcase
        end
    end

    // Transaction FSM with registered completion and beat-valid flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= IDLE;
            cnt_r    <= CNT_ZERO;
            beat_r   <= BEAT_ZERO;
            mrw_r    <= MRW_READ;
            addr_r   <= {IDX_W{1'b0}};
            data_r   <= {DATA_W{1'b0}};
            mvalid_r <= 1'b0;
            mrdy_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    mvalid_r <= 1'b0;
                    mrdy_r   <= 1'b0;
                    if (MStrobe) begin
                        mrw_r   <= MRW;
                        addr_r  <= MAddr[IDX_W-1:0];
                        data_r  <= MDataW;
                        cnt_r   <= LAT_LOAD;
                        state_r <= WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_r == CNT_ZERO) begin
                        if (mrw_r == MRW_WRITE) begin
                            mrdy_r  <= 1'b1;
                            state_r <= WRITE;
                        end else begin
                            beat_r   <= BEAT_ZERO;
                            mvalid_r <= 1'b1;
                            mrdy_r   <= SINGLE_BEAT;
                            state_r  <= BURST;
                        end
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                BURST: begin
                    if (beat_r == LAST_BEAT) begin
                        mvalid_r <= 1'b0;
                        mrdy_r   <= 1'b0;
                        state_r  <= HOLD;
                    end else begin
                        beat_r <= beat_r + BEAT_ONE;
                        mrdy_r <= ((beat_r + BEAT_ONE) == LAST_BEAT);
                    end
                end
                WRITE: begin
                    mrdy_r  <= 1'b0;
                    state_r <= HOLD;
                end
                HOLD: begin
                    if (!MStrobe) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= HOLD;
                    end
                end
                default: begin
                    mvalid_r <= 1'b0;
                    mrdy_r   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_mem_array (
        .clk   (clk),
        .reset (reset),
        .we    (we_s),
        .re    (re_s),
        .addr  (ram_addr_s),
        .wdata (data_r),
        .rdata (MDataR)
    );

    assign MValid = mvalid_r;
    assign MRdy   = mrdy_r;
    assign MBusy  = (state_r != IDLE);

endmodule
